// File: rtl/loop_replay_unit.sv
// Loop replay unit: replays a captured loop body from a local buffer until abort or reset.
// Optional iteration cap is enabled by defining REPLAY_ITER_LIMIT_EN (cap value ITER_LIMIT).
module loop_replay_unit #(
    parameter int LOOP_DEPTH = 32,
    parameter int ITER_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_we,
    input  logic [4:0]  cap_addr,
    input  logic [31:0] cap_instr,
    input  logic        loop_commit,
    input  logic [5:0]  loop_len,
    input  logic [31:0] loop_start_pc,
    input  logic        mispredict,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        replay_active,
    output logic [15:0] iter_count,
    output logic        replay_done
);
    localparam int AW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam logic [6:0] DEPTH_LEN = 7'(LOOP_DEPTH);
`ifdef REPLAY_ITER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] buffer [LOOP_DEPTH];
    logic [5:0]  len_q;
    logic [5:0]  index_q, index_d;
    logic [5:0]  rd_idx;
    logic [31:0] start_pc_q;
    logic [15:0] iter_q, iter_inc;
    logic        commit_ok, transfer, wrap, limit_hit, rd_en;

    // mispredict outranks a same-cycle commit, and every transfer/wrap
    assign commit_ok = loop_commit && !mispredict && (loop_len != 6'd0)
                       && ({1'b0, loop_len} <= DEPTH_LEN);
    assign transfer  = (state_q == STREAM) && !stall && !mispredict;
    assign wrap      = transfer && (index_q == len_q - 6'd1);
    assign iter_inc  = (iter_q == 16'hFFFF) ? iter_q : iter_q + 16'd1;
    assign limit_hit = LIMIT_EN && wrap && ({16'h0, iter_inc} == 32'(ITER_LIMIT));

    assign replay_active = (state_q != IDLE);
    assign iter_count    = iter_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        rd_en   = 1'b0;
        rd_idx  = index_q;
        case (state_q)
            IDLE: begin
                if (commit_ok) begin
                    state_d = PRIME;
                    index_d = '0;
                end
            end
            PRIME: begin
                if (mispredict) begin
                    state_d = IDLE;
                end else begin
                    state_d = STREAM;
                    rd_en   = 1'b1;
                    rd_idx  = '0;
                end
            end
            STREAM: begin
                if (mispredict) begin
                    state_d = IDLE;
                end else if (transfer) begin
                    index_d = wrap ? 6'd0 : index_q + 6'd1;
                    rd_en   = 1'b1;
                    rd_idx  = index_d;
                    if (limit_hit) begin
                        state_d = IDLE;
                        rd_en   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer is capture-writable only while idle and survives reset
    always_ff @(posedge clk) begin
        if (cap_we && (state_q == IDLE) && ({2'b00, cap_addr} < DEPTH_LEN)) begin
            buffer[AW'(cap_addr)] <= cap_instr;
        end
    end

    // The next entry is fetched on the transfer edge itself, so a stall simply skips the read
    always_ff @(posedge clk) begin
        if (reset) begin
            index_q         <= '0;
            len_q           <= '0;
            start_pc_q      <= '0;
            iter_q          <= '0;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
        end else begin
            index_q   <= index_d;
            out_valid <= (state_d == STREAM);
            if ((state_q == IDLE) && commit_ok) begin
                len_q      <= loop_len;
                start_pc_q <= loop_start_pc;
                iter_q     <= '0;
            end else if (wrap) begin
                iter_q <= iter_inc;
            end
            if (rd_en) begin
                out_instruction <= buffer[AW'(rd_idx)];
                out_pc          <= start_pc_q + {24'h0, rd_idx, 2'b00};
            end
        end
    end

`ifdef REPLAY_ITER_LIMIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            replay_done <= 1'b0;
        end else begin
            replay_done <= limit_hit;
        end
    end
`else
    assign replay_done = 1'b0;
`endif

endmodule

// File: tb/tb_loop_replay_unit.sv
// Self-checking bench for loop_replay_unit: directed scenarios plus randomized replay against a stream model.
module tb_loop_replay_unit;
    localparam int LIM = 2;
`ifdef REPLAY_ITER_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cap_we = 1'b0;
    logic [4:0]  cap_addr = '0;
    logic [31:0] cap_instr = '0;
    logic        loop_commit = 1'b0;
    logic [5:0]  loop_len = '0;
    logic [31:0] loop_start_pc = '0;
    logic        mispredict = 1'b0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        replay_active;
    logic [15:0] iter_count;
    logic        replay_done;

    int total = 0;
    int bad = 0;

    // Model: buffer image, committed loop, and number of transfers since commit
    logic [31:0] mem_m [32];
    int          m_len = 1;
    logic [31:0] m_pc = '0;
    int          k = 0;

    always #5 clk = ~clk;

    loop_replay_unit #(.LOOP_DEPTH(32), .ITER_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .cap_we(cap_we), .cap_addr(cap_addr), .cap_instr(cap_instr),
        .loop_commit(loop_commit), .loop_len(loop_len), .loop_start_pc(loop_start_pc),
        .mispredict(mispredict), .stall(stall), .out_valid(out_valid),
        .out_instruction(out_instruction), .out_pc(out_pc), .replay_active(replay_active),
        .iter_count(iter_count), .replay_done(replay_done)
    );

    function automatic logic [31:0] e_instr();
        return mem_m[k % m_len];
    endfunction

    function automatic logic [31:0] e_pc();
        return m_pc + 32'(4 * (k % m_len));
    endfunction

    function automatic logic [15:0] e_iter();
        int it;
        it = k / m_len;
        return (it > 65535) ? 16'hFFFF : 16'(it);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        cap_we = 1'b1; cap_addr = 5'(a); cap_instr = d;
        tick();
        cap_we = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic commit(input int len, input logic [31:0] pc);
        loop_commit = 1'b1; loop_len = 6'(len); loop_start_pc = pc;
        tick();
        loop_commit = 1'b0;
        m_len = len; m_pc = pc; k = 0;
    endtask

    task automatic abort();
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_instruction !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", out_instruction); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", out_pc); end
        total++; if ({replay_active, replay_done, iter_count} !== 18'h0) begin bad++; $display("FAIL reset_ctrl got act=%b done=%b it=%0d want 0", replay_active, replay_done, iter_count); end
    endtask

    task automatic test_basic();
        logic [31:0] pcs [4];
        pcs = '{32'h100, 32'h104, 32'h108, 32'h100};
        write_word(0, 32'h00000013);
        write_word(1, 32'h00108093);
        write_word(2, 32'h00210113);
        commit(3, 32'h100);
        total++; if ({out_valid, replay_active} !== 2'b01) begin bad++; $display("FAIL basic_prime got v=%b act=%b want v=0 act=1", out_valid, replay_active); end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if ({out_valid, out_pc} !== {1'b1, pcs[i]}) begin bad++; $display("FAIL basic_pc i=%0d got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, pcs[i]); end
            total++; if ({out_instruction, iter_count} !== {e_instr(), e_iter()}) begin bad++; $display("FAIL basic_stream k=%0d got i=%h it=%0d want i=%h it=%0d", k, out_instruction, iter_count, e_instr(), e_iter()); end
            if (i == 3) begin
                total++; if (iter_count !== 16'd1) begin bad++; $display("FAIL basic_iter got=%0d want=1", iter_count); end
            end
            tick(); k++;
        end
        abort();
    endtask

    task automatic test_stall();
        commit(3, 32'h100);
        tick();
        tick(); k++;
        total++; if ({out_valid, out_pc} !== {1'b1, 32'h104}) begin bad++; $display("FAIL stall_pre got v=%b pc=%h want v=1 pc=104", out_valid, out_pc); end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({out_valid, out_instruction, out_pc} !== {1'b1, 32'h00108093, 32'h104}) begin bad++; $display("FAIL stall_hold c=%0d got v=%b i=%h pc=%h want v=1 i=00108093 pc=104", i, out_valid, out_instruction, out_pc); end
        end
        stall = 1'b0;
        tick(); k++;
        total++; if ({out_instruction, out_pc} !== {32'h00210113, 32'h108}) begin bad++; $display("FAIL stall_release got i=%h pc=%h want i=00210113 pc=108", out_instruction, out_pc); end
    endtask

    task automatic test_mispredict();
        tick(); k++;
        stall = 1'b1; mispredict = 1'b1;
        tick();
        stall = 1'b0; mispredict = 1'b0;
        total++; if ({out_valid, replay_active} !== 2'b00) begin bad++; $display("FAIL mp_exit got v=%b act=%b want 0 0", out_valid, replay_active); end
        total++; if (iter_count !== 16'd1) begin bad++; $display("FAIL mp_iter_hold got=%0d want=1", iter_count); end
        write_word(0, 32'hDEADBEEF);
        loop_commit = 1'b1; loop_len = 6'd1; loop_start_pc = 32'h200; mispredict = 1'b1;
        tick();
        loop_commit = 1'b0; mispredict = 1'b0;
        tick();
        total++; if ({out_valid, replay_active} !== 2'b00) begin bad++; $display("FAIL mp_commit_drop got v=%b act=%b want 0 0", out_valid, replay_active); end
        commit(1, 32'h300);
        tick();
        total++; if ({out_valid, out_instruction, out_pc} !== {1'b1, 32'hDEADBEEF, 32'h300}) begin bad++; $display("FAIL mp_rewrite got v=%b i=%h pc=%h want v=1 i=deadbeef pc=300", out_valid, out_instruction, out_pc); end
        abort();
    endtask

    task automatic test_bad_len();
        int n;
        logic [5:0] lens [2];
        lens = '{6'd0, 6'd33};
        for (int j = 0; j < 2; j++) begin
            loop_commit = 1'b1; loop_len = lens[j]; loop_start_pc = 32'h500;
            tick();
            loop_commit = 1'b0;
            total++; if ({out_valid, replay_active} !== 2'b00) begin bad++; $display("FAIL badlen_a len=%0d got v=%b act=%b want 0 0", lens[j], out_valid, replay_active); end
            tick();
            total++; if ({out_valid, replay_active} !== 2'b00) begin bad++; $display("FAIL badlen_b len=%0d got v=%b act=%b want 0 0", lens[j], out_valid, replay_active); end
        end
        commit(1, 32'hFFFFFFFC);
        tick();
        n = LIM_EN ? LIM : 6;
        for (int i = 0; i < n; i++) begin
            total++; if ({out_valid, out_pc, iter_count} !== {1'b1, 32'hFFFFFFFC, e_iter()}) begin bad++; $display("FAIL len1 k=%0d got v=%b pc=%h it=%0d want v=1 pc=fffffffc it=%0d", k, out_valid, out_pc, iter_count, e_iter()); end
            tick(); k++;
        end
        abort();
    endtask

    task automatic test_iter_limit();
        int xfers, dones;
        write_word(0, $urandom);
        write_word(1, $urandom);
        commit(2, 32'h400);
        xfers = 0; dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid && !stall) xfers++;
            if (replay_done) dones++;
        end
`ifdef REPLAY_ITER_LIMIT_EN
        total++; if (xfers !== 4) begin bad++; $display("FAIL limit_xfers got=%0d want=4", xfers); end
        total++; if (dones !== 1) begin bad++; $display("FAIL limit_done got=%0d want=1", dones); end
        total++; if ({replay_active, iter_count} !== {1'b0, 16'd2}) begin bad++; $display("FAIL limit_idle got act=%b it=%0d want act=0 it=2", replay_active, iter_count); end
`else
        total++; if (xfers !== 12) begin bad++; $display("FAIL nolimit_xfers got=%0d want=12", xfers); end
        total++; if (dones !== 0) begin bad++; $display("FAIL nolimit_done got=%0d want=0", dones); end
        total++; if ({replay_active, iter_count} !== {1'b1, 16'd5}) begin bad++; $display("FAIL nolimit_run got act=%b it=%0d want act=1 it=5", replay_active, iter_count); end
`endif
        abort();
    endtask

    task automatic test_random();
        bit          active, done_exp, st;
        logic [15:0] hold_iter;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 32; a++) write_word(a, $urandom);
            commit($urandom_range(1, 32), (r == 0) ? 32'hFFFFFFF0 : 32'($urandom));
            total++; if ({out_valid, replay_active} !== 2'b01) begin bad++; $display("FAIL rand_prime r=%0d got v=%b act=%b want v=0 act=1", r, out_valid, replay_active); end
            tick();
            active = 1'b1; done_exp = 1'b0;
            for (int c = 0; c < 60; c++) begin
                if (active) begin
                    total++; if ({out_valid, out_instruction, out_pc, iter_count, replay_active, replay_done} !== {1'b1, e_instr(), e_pc(), e_iter(), 1'b1, 1'b0}) begin bad++; $display("FAIL rand_stream r=%0d k=%0d got v=%b i=%h pc=%h it=%0d want i=%h pc=%h it=%0d", r, k, out_valid, out_instruction, out_pc, iter_count, e_instr(), e_pc(), e_iter()); end
                end else begin
                    total++; if ({out_valid, replay_active, replay_done, iter_count} !== {1'b0, 1'b0, done_exp, 16'(LIM)}) begin bad++; $display("FAIL rand_limit r=%0d got v=%b act=%b done=%b it=%0d want v=0 act=0 done=%b it=%0d", r, out_valid, replay_active, replay_done, iter_count, done_exp, LIM); end
                end
                st = ($urandom_range(0, 99) < 30);
                stall = st;
                cap_we = active && ($urandom_range(0, 3) == 0);
                cap_addr = 5'($urandom); cap_instr = $urandom;
                loop_commit = active && ($urandom_range(0, 7) == 0);
                loop_len = 6'($urandom_range(1, 32)); loop_start_pc = $urandom;
                tick();
                cap_we = 1'b0; loop_commit = 1'b0;
                done_exp = 1'b0;
                if (active && !st) begin
                    k++;
                    if (LIM_EN && (k == LIM * m_len)) begin
                        active = 1'b0; done_exp = 1'b1;
                    end
                end
            end
            hold_iter = active ? e_iter() : 16'(LIM);
            stall = 1'($urandom); loop_commit = 1'($urandom); loop_len = 6'd4;
            abort();
            stall = 1'b0; loop_commit = 1'b0;
            total++; if ({out_valid, replay_active, replay_done, iter_count} !== {3'b000, hold_iter}) begin bad++; $display("FAIL rand_abort r=%0d got v=%b act=%b done=%b it=%0d want 0 0 0 it=%0d", r, out_valid, replay_active, replay_done, iter_count, hold_iter); end
            tick();
            total++; if (replay_active !== 1'b0) begin bad++; $display("FAIL rand_idle r=%0d got act=%b want 0", r, replay_active); end
        end
    endtask

    task automatic test_reset_mid();
        commit(5, 32'h1000);
        tick();
        for (int i = 0; i < 3; i++) begin tick(); k++; end
        reset = 1'b1; stall = 1'($urandom); loop_commit = 1'b1; loop_len = 6'd3;
        tick();
        reset = 1'b0; stall = 1'b0; loop_commit = 1'b0;
        total++; if ({out_valid, out_instruction, out_pc, iter_count, replay_active, replay_done} !== 83'h0) begin bad++; $display("FAIL rmid_zero got v=%b i=%h pc=%h it=%0d act=%b done=%b want all 0", out_valid, out_instruction, out_pc, iter_count, replay_active, replay_done); end
        commit(5, 32'h1000);
        tick();
        for (int i = 0; i < 7; i++) begin
            total++; if ({out_valid, out_instruction, out_pc, iter_count} !== {1'b1, e_instr(), e_pc(), e_iter()}) begin bad++; $display("FAIL rmid_replay k=%0d got v=%b i=%h pc=%h it=%0d want i=%h pc=%h it=%0d", k, out_valid, out_instruction, out_pc, iter_count, e_instr(), e_pc(), e_iter()); end
            tick(); k++;
        end
        abort();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_mispredict();
        test_bad_len();
        test_iter_limit();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
